// File: rtl/rtl_handshake_feeder_if.sv
// Ready/valid operand channel carrying an in1/in2 pair.
// The master drives valid and payload, and the slave answers with ready.
`timescale 1ns/1ps
interface rtl_handshake_feeder_if #(
   parameter int WIDTH = 4
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;

   modport master (output valid, output in1, output in2, input ready);
   modport slave  (input valid, input in1, input in2, output ready);
endinterface

// File: rtl/rtl_handshake_feeder.sv
// Round-robin merge of three producer channels into one FIFO-buffered channel
// toward the RTL datapath. The head is read straight from the FIFO, so a beat appears one cycle after it is accepted.
`timescale 1ns/1ps
module rtl_handshake_feeder #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   rtl_handshake_feeder_if.slave    handshake_arr_0,
   rtl_handshake_feeder_if.slave    handshake_arr_1,
   rtl_handshake_feeder_if.slave    handshake_arr_2,
   rtl_handshake_feeder_if.master   handshake,
   output logic [1:0]               src,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * WIDTH + 2;

   // Slot 3 is a permanently idle channel so a 2-bit index is always in range.
   logic [3:0]       arr_valid;
   logic [WIDTH-1:0] arr_in1 [4];
   logic [WIDTH-1:0] arr_in2 [4];
   logic [2:0]       arr_ready;

   logic [1:0]    last_reg;
   logic [AW-1:0] wptr_reg;
   logic [AW-1:0] rptr_reg;
   logic [CW-1:0] count_reg;
   logic [EW-1:0] mem_reg [DEPTH];

   logic [1:0]    cand1, cand2, cand3;
   logic [1:0]    grant;
   logic          grant_valid;
   logic          full, empty;
   logic          push, pop;
   logic          out_valid;
   logic [EW-1:0] wdata;
   logic [EW-1:0] head;

   function automatic logic [1:0] next_ch(input logic [1:0] ch);
      return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
   endfunction

   assign arr_valid  = {1'b0, handshake_arr_2.valid, handshake_arr_1.valid, handshake_arr_0.valid};
   assign arr_in1[0] = handshake_arr_0.in1;
   assign arr_in1[1] = handshake_arr_1.in1;
   assign arr_in1[2] = handshake_arr_2.in1;
   assign arr_in1[3] = '0;
   assign arr_in2[0] = handshake_arr_0.in2;
   assign arr_in2[1] = handshake_arr_1.in2;
   assign arr_in2[2] = handshake_arr_2.in2;
   assign arr_in2[3] = '0;

   // The search starts just after the last granted channel, so the last one is checked last.
   always_comb begin
      cand1       = next_ch(last_reg);
      cand2       = next_ch(cand1);
      cand3       = next_ch(cand2);
      grant       = cand1;
      grant_valid = 1'b0;
      if (arr_valid[cand1]) begin
         grant       = cand1;
         grant_valid = 1'b1;
      end else if (arr_valid[cand2]) begin
         grant       = cand2;
         grant_valid = 1'b1;
      end else if (arr_valid[cand3]) begin
         grant       = cand3;
         grant_valid = 1'b1;
      end
   end

   assign full      = (count_reg == CW'(DEPTH));
   assign empty     = (count_reg == '0);
   // Freed space is not passed through in the same cycle, so readies never see a pop.
   assign push      = grant_valid && !full && !RESET;
   assign out_valid = !empty && !RESET;
   assign pop       = out_valid && handshake.ready;
   assign wdata     = {arr_in1[grant], arr_in2[grant], grant};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ready
         assign arr_ready[gi] = push && (grant == 2'(gi));
      end
   endgenerate

   assign handshake_arr_0.ready = arr_ready[0];
   assign handshake_arr_1.ready = arr_ready[1];
   assign handshake_arr_2.ready = arr_ready[2];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
         last_reg  <= 2'd2;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_reg[wptr_reg] <= wdata;
            wptr_reg          <= wptr_reg + 1'b1;
            last_reg          <= grant;
         end
         if (pop) begin
            rptr_reg <= rptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head            = mem_reg[rptr_reg];
   assign handshake.valid = out_valid;
   assign handshake.in1   = head[EW-1 -: WIDTH];
   assign handshake.in2   = head[WIDTH+1 -: WIDTH];
   assign src             = head[1:0];
   assign count           = count_reg;
endmodule
